axi_slave_wr_ctrl: RTL and testbench

//  Write-channel controller for the AXI slave. Sequences AW -> W burst -> B on the shared axi_intf

---
 rtl/axi_pkg.sv | 42 ++++
 rtl/axi_slave_wr_ctrl_if.sv | 44 ++++
 rtl/axi_burst_addr_gen.sv | 76 +++++++
 rtl/axi_slave_wr_ctrl.sv | 150 +++++++++++++++
 tb/tb_axi_slave_wr_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// ============================================================================
// Module : axi_pkg
// Brief  : Shared types and constants for the AXI slave write controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_exokay = 2'b01;
  localparam logic [1:0] c_resp_slverr = 2'b10;
  localparam logic [1:0] c_resp_decerr = 2'b11;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2
  } wr_state_e;

  // Only power-of-two burst lengths of 2..16 beats are legal for WRAP.
  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

  // DECERR is sticky and dominates; otherwise a flagged beat raises SLVERR.
  function automatic logic [1:0] resp_merge(input logic [1:0] cur, input logic slv_flag);
    if (cur == c_resp_decerr) return cur;
    if (slv_flag) return c_resp_slverr;
    return cur;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_slave_wr_ctrl_if.sv
// ============================================================================
// Module : axi_slave_wr_ctrl_if
// Brief  : AXI write-channel bundle (AW, W, B) with master/slave views.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface axi_slave_wr_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic [3:0]        awid;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;
  logic [3:0]        wid;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [3:0]        bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wid, wdata, wstrb, wlast, wvalid,
    output bready,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wid, wdata, wstrb, wlast, wvalid,
    input  bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
// ============================================================================
// Module : axi_burst_addr_gen
// Brief  : Registered burst byte address with FIXED/INCR/WRAP stepping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int AW = 12
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          load,
  input  wire logic [AW-1:0] load_addr,
  input  wire burst_e        load_burst,
  input  wire logic [2:0]    load_size,
  input  wire logic [3:0]    load_len,
  input  wire logic          advance,
  output logic      [AW-1:0] cur_addr
);

  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] incr_q, incr_d;
  logic [AW-1:0] mask_q, mask_d;
  burst_e        burst_q, burst_d;
  logic [AW-1:0] w_incr_sum;
  logic [AW-1:0] w_next;

  assign w_incr_sum = addr_q + incr_q;

  // WRAP keeps the bits above the (len+1)<<size window and steps within it.
  always_comb begin
    w_next = addr_q;
    case (burst_q)
      BURST_INCR: w_next = w_incr_sum;
      BURST_WRAP: w_next = (addr_q & ~mask_q) | (w_incr_sum & mask_q);
      default:    w_next = addr_q;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    incr_d  = incr_q;
    mask_d  = mask_q;
    burst_d = burst_q;
    if (load) begin
      addr_d  = load_addr;
      burst_d = load_burst;
      incr_d  = AW'(1) << load_size;
      mask_d  = (AW'({1'b0, load_len} + 5'd1) << load_size) - AW'(1);
    end else if (advance) begin
      addr_d = w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      incr_q  <= '0;
      mask_q  <= '0;
      burst_q <= BURST_FIXED;
    end else begin
      addr_q  <= addr_d;
      incr_q  <= incr_d;
      mask_q  <= mask_d;
      burst_q <= burst_d;
    end
  end

  assign cur_addr = addr_q;

endmodule

`default_nettype wire

// File: rtl/axi_slave_wr_ctrl.sv
// ============================================================================
// Module : axi_slave_wr_ctrl
// Brief  : AXI slave write controller, AW -> W burst -> B, drives SRAM port.
//          Optional wid checking under macro AXI_WR_WID_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axi_slave_wr_ctrl
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 10
) (
  input  wire logic              aclk,
  input  wire logic              arst,
  axi_slave_wr_ctrl_if.slave     axi,
  output logic                   mem_we,
  output logic      [MEM_AW-1:0] mem_addr,
  output logic      [31:0]       mem_wdata,
  output logic      [3:0]        mem_be
);

  wr_state_e   state_q, state_d;
  logic [3:0]  awid_q, awid_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic [1:0]  err_q, err_d;
  logic        suppress_q, suppress_d;

  logic              w_aw_ready;
  logic              w_w_ready;
  logic              w_b_valid;
  logic              w_we;
  logic              w_aw_load;
  logic              w_beat_adv;
  logic              w_decerr;
  logic              w_cfg_err;
  logic              w_last_exp;
  logic              w_wid_bad;
  logic              w_unused;
  logic [MEM_AW+1:0] w_cur_addr;

  assign w_decerr   = |axi.awaddr[ADDR_W-1:MEM_AW+2];
  assign w_cfg_err  = (axi.awsize > 3'd2)
                    || (axi.awburst == BURST_RSVD)
                    || ((axi.awburst == BURST_WRAP) && !wrap_len_ok(axi.awlen));
  assign w_last_exp = (beat_cnt_q == len_q);

`ifdef AXI_WR_WID_CHECK_EN
  assign w_wid_bad = (axi.wid != awid_q);
  assign w_unused  = ^w_cur_addr[1:0];
`else
  assign w_wid_bad = 1'b0;
  assign w_unused  = ^{axi.wid, w_cur_addr[1:0]};
`endif

  always_comb begin
    state_d    = state_q;
    awid_d     = awid_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    suppress_d = suppress_q;
    w_aw_ready = 1'b0;
    w_w_ready  = 1'b0;
    w_b_valid  = 1'b0;
    w_we       = 1'b0;
    w_aw_load  = 1'b0;
    w_beat_adv = 1'b0;
    case (state_q)
      WR_IDLE: begin
        w_aw_ready = 1'b1;
        if (axi.awvalid) begin
          w_aw_load  = 1'b1;
          awid_d     = axi.awid;
          len_d      = axi.awlen;
          beat_cnt_d = '0;
          suppress_d = w_decerr || w_cfg_err;
          err_d      = w_decerr  ? c_resp_decerr :
                       w_cfg_err ? c_resp_slverr : c_resp_okay;
          state_d    = WR_DATA;
        end
      end
      WR_DATA: begin
        w_w_ready = 1'b1;
        if (axi.wvalid) begin
          // A bad wlast flags the burst but the beat is still written.
          w_beat_adv = 1'b1;
          w_we       = !suppress_q && !w_wid_bad;
          err_d      = resp_merge(err_q, (axi.wlast != w_last_exp) || w_wid_bad);
          beat_cnt_d = beat_cnt_q + 4'd1;
          if (w_last_exp) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        w_b_valid = 1'b1;
        if (axi.bready) state_d = WR_IDLE;
      end
      default: state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q    <= WR_IDLE;
      awid_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      err_q      <= c_resp_okay;
      suppress_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      awid_q     <= awid_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      suppress_q <= suppress_d;
    end
  end

  axi_burst_addr_gen #(
    .AW (MEM_AW + 2)
  ) u_addr_gen (
    .clk        (aclk),
    .rst        (arst),
    .load       (w_aw_load),
    .load_addr  (axi.awaddr[MEM_AW+1:0]),
    .load_burst (burst_e'(axi.awburst)),
    .load_size  (axi.awsize),
    .load_len   (axi.awlen),
    .advance    (w_beat_adv),
    .cur_addr   (w_cur_addr)
  );

  // Every output is forced low while reset is held, regardless of state.
  assign axi.awready = w_aw_ready && !arst;
  assign axi.wready  = w_w_ready && !arst;
  assign axi.bvalid  = w_b_valid && !arst;
  assign axi.bid     = (w_b_valid && !arst) ? awid_q : 4'd0;
  assign axi.bresp   = (w_b_valid && !arst) ? err_q : 2'd0;

  assign mem_we    = w_we && !arst;
  assign mem_addr  = arst ? '0 : w_cur_addr[MEM_AW+1:2];
  assign mem_wdata = arst ? 32'd0 : axi.wdata;
  assign mem_be    = arst ? 4'd0 : axi.wstrb;

endmodule

`default_nettype wire

// File: tb/tb_axi_slave_wr_ctrl.sv
// ============================================================================
// Module : tb_axi_slave_wr_ctrl
// Brief  : Self-checking bench for axi_slave_wr_ctrl with a burst-level model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axi_slave_wr_ctrl;

  localparam int ADDR_W = 32;
  localparam int MEM_AW = 10;
`ifdef AXI_WR_WID_CHECK_EN
  localparam bit WID_CHK = 1'b1;
`else
  localparam bit WID_CHK = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]        id;
    logic [31:0]       addr;
    logic [3:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [1:0]        wl;
    logic              wid_bad_en;
    logic [3:0]        wid_bad_k;
    logic              gap;
    logic [2:0]        bdly;
    logic [15:0][31:0] data;
    logic [15:0][3:0]  strb;
  } burst_t;

  logic              clk = 1'b0;
  logic              arst;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  int                n_chk = 0;
  int                n_fail = 0;

  axi_slave_wr_ctrl_if #(.ADDR_W(ADDR_W)) axi ();

  axi_slave_wr_ctrl #(.ADDR_W(ADDR_W), .MEM_AW(MEM_AW)) dut (
    .aclk      (clk),
    .arst      (arst),
    .axi       (axi.slave),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model (burst-level arithmetic) ----------------
  function automatic logic [31:0] beat_byte(input burst_t b, input int k);
    logic [31:0] sz, wb, base, kk;
    sz = 32'd1 << b.size;
    wb = (32'(b.len) + 32'd1) * sz;
    kk = 32'(k);
    case (b.burst)
      2'b01:   beat_byte = b.addr + kk * sz;
      2'b10: begin
        base      = b.addr - (b.addr % wb);
        beat_byte = base + ((b.addr - base + kk * sz) % wb);
      end
      default: beat_byte = b.addr;
    endcase
  endfunction

  function automatic bit is_dec(input burst_t b);
    return b.addr[ADDR_W-1:MEM_AW+2] != '0;
  endfunction

  function automatic bit is_cfg(input burst_t b);
    return (b.size > 3'd2) || (b.burst == 2'b11) ||
           ((b.burst == 2'b10) && !(b.len inside {4'd1, 4'd3, 4'd7, 4'd15}));
  endfunction

  function automatic bit beat_wid_bad(input burst_t b, input int k);
    return WID_CHK && b.wid_bad_en && (4'(k) == b.wid_bad_k);
  endfunction

  function automatic logic [1:0] exp_resp(input burst_t b);
    if (is_dec(b)) return 2'b11;
    if (is_cfg(b) || (b.wl != 2'd0) || (WID_CHK && b.wid_bad_en)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic wlast_of(input burst_t b, input int k);
    case (b.wl)
      2'd0:    return 4'(k) == b.len;
      2'd1:    return (b.len != 4'd0) && (k == 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic burst_t mk(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                                input logic [2:0] size, input logic [1:0] bt, input logic [1:0] wl);
    burst_t r;
    r = '0;
    r.id = id; r.addr = addr; r.len = len; r.size = size; r.burst = bt; r.wl = wl;
    for (int i = 0; i < 16; i++) begin
      r.data[i] = $urandom;
      r.strb[i] = 4'hF;
    end
    return r;
  endfunction

  function automatic burst_t rnd();
    burst_t r;
    int v;
    v = $urandom_range(0, 9);
    r = mk(4'($urandom), 32'(12'($urandom)), 4'($urandom), 3'($urandom_range(0, 2)),
           (v < 2) ? 2'b00 : (v < 6) ? 2'b01 : (v < 9) ? 2'b10 : 2'b11, 2'd0);
    if (r.burst == 2'b10 && $urandom_range(0, 4) != 0) r.len = 4'd1 << $urandom_range(1, 4) - 1;
    if ($urandom_range(0, 9) == 0) r.size = 3'd3;
    if ($urandom_range(0, 9) == 0) r.addr = $urandom | 32'h0001_0000;
    if ($urandom_range(0, 9) == 0) r.wl = 2'($urandom_range(1, 2));
    if ($urandom_range(0, 7) == 0) begin
      r.wid_bad_en = 1'b1;
      r.wid_bad_k  = 4'($urandom_range(0, 32'(r.len)));
    end
    r.gap  = 1'($urandom);
    r.bdly = 3'($urandom_range(0, 3));
    for (int i = 0; i < 16; i++) r.strb[i] = 4'($urandom);
    return r;
  endfunction

  // Entered and left at a falling edge; optionally presents the next AW during B.
  task automatic do_burst(input burst_t b, input burst_t nxt, input bit pend);
    int  waited;
    bit  we_exp;
    axi.awid = b.id; axi.awaddr = b.addr; axi.awlen = b.len;
    axi.awsize = b.size; axi.awburst = b.burst; axi.awvalid = 1'b1;
    waited = 0;
    #1;
    while (axi.awready !== 1'b1 && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    chk("aw_accept", 64'(waited < 20), 64'd1);
    @(posedge clk); #1;
    axi.awvalid = 1'b0;
    for (int k = 0; k <= int'(b.len); k++) begin
      if (b.gap && $urandom_range(0, 2) == 0) begin
        axi.wvalid = 1'b0;
        @(negedge clk);
        chk("gap_wready", 64'(axi.wready), 64'd1);
        chk("gap_we", 64'(mem_we), 64'd0);
        @(posedge clk); #1;
      end
      axi.wvalid = 1'b1;
      axi.wdata  = b.data[4'(k)];
      axi.wstrb  = b.strb[4'(k)];
      axi.wlast  = wlast_of(b, k);
      axi.wid    = WID_CHK ? (beat_wid_bad(b, k) ? ~b.id : b.id) : 4'($urandom);
      @(negedge clk);
      chk("wready", 64'(axi.wready), 64'd1);
      chk("awready_in_data", 64'(axi.awready), 64'd0);
      we_exp = !is_dec(b) && !is_cfg(b) && !beat_wid_bad(b, k);
      chk("mem_we", 64'(mem_we), 64'(we_exp));
      if (we_exp) begin
        chk("mem_addr", 64'(mem_addr), 64'(MEM_AW'(beat_byte(b, k) >> 2)));
        chk("mem_wdata", 64'(mem_wdata), 64'(b.data[4'(k)]));
        chk("mem_be", 64'(mem_be), 64'(b.strb[4'(k)]));
      end
      @(posedge clk); #1;
    end
    axi.wvalid = 1'b0;
    axi.wlast  = 1'b0;
    if (pend) begin
      axi.awid = nxt.id; axi.awaddr = nxt.addr; axi.awlen = nxt.len;
      axi.awsize = nxt.size; axi.awburst = nxt.burst; axi.awvalid = 1'b1;
    end
    @(negedge clk);
    chk("bvalid", 64'(axi.bvalid), 64'd1);
    chk("bid", 64'(axi.bid), 64'(b.id));
    chk("bresp", 64'(axi.bresp), 64'(exp_resp(b)));
    chk("wready_in_resp", 64'(axi.wready), 64'd0);
    chk("awready_in_resp", 64'(axi.awready), 64'd0);
    for (int d = 0; d < int'(b.bdly); d++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bvalid_hold", 64'(axi.bvalid), 64'd1);
      chk("awready_hold", 64'(axi.awready), 64'd0);
    end
    axi.bready = 1'b1;
    @(posedge clk); #1;
    axi.bready = 1'b0;
    @(negedge clk);
    chk("awready_after_b", 64'(axi.awready), 64'd1);
    chk("bvalid_after_b", 64'(axi.bvalid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    burst_t b, nb, dummy;
    dummy = '0;
    arst = 1'b1;
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
    axi.awvalid = 1'b0; axi.wid = '0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0;
    axi.wvalid = 1'b0; axi.bready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 64'(axi.awready), 64'd0);
    chk("rst_wready", 64'(axi.wready), 64'd0);
    chk("rst_bvalid", 64'(axi.bvalid), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    @(posedge clk); #1;
    arst = 1'b0;
    @(negedge clk);
    chk("idle_awready", 64'(axi.awready), 64'd1);

    b = mk(4'h5, 32'h100, 4'd3, 3'd2, 2'b01, 2'd0);
    for (int i = 0; i < 4; i++) b.data[i] = 32'hA0 + 32'(i);
    do_burst(b, dummy, 1'b0);
    do_burst(mk(4'h6, 32'h38, 4'd3, 3'd2, 2'b10, 2'd0), dummy, 1'b0);
    b = mk(4'h7, 32'h20, 4'd2, 3'd2, 2'b00, 2'd0);
    b.strb[0] = 4'h1; b.strb[1] = 4'h2; b.strb[2] = 4'h4;
    do_burst(b, dummy, 1'b0);
    do_burst(mk(4'h8, 32'h0001_0000, 4'd1, 3'd2, 2'b01, 2'd0), dummy, 1'b0);
    do_burst(mk(4'h9, 32'h40, 4'd1, 3'd3, 2'b01, 2'd0), dummy, 1'b0);
    do_burst(mk(4'hA, 32'h80, 4'd3, 3'd2, 2'b01, 2'd1), dummy, 1'b0);
    do_burst(mk(4'hB, 32'hFF8, 4'd3, 3'd2, 2'b01, 2'd0), dummy, 1'b0);
    b = mk(4'hC, 32'h200, 4'd1, 3'd2, 2'b01, 2'd0);
    b.bdly = 3'd5;
    nb = mk(4'hD, 32'h300, 4'd1, 3'd2, 2'b01, 2'd0);
    do_burst(b, nb, 1'b1);
    do_burst(nb, dummy, 1'b0);
    if (WID_CHK) begin
      b = mk(4'h3, 32'h180, 4'd3, 3'd2, 2'b01, 2'd0);
      b.wid_bad_en = 1'b1; b.wid_bad_k = 4'd1;
      do_burst(b, dummy, 1'b0);
    end

    // Reset lands on beat 2 of a 4-beat burst.
    axi.awid = 4'h2; axi.awaddr = 32'h240; axi.awlen = 4'd3; axi.awsize = 3'd2;
    axi.awburst = 2'b01; axi.awvalid = 1'b1;
    @(posedge clk); #1;
    axi.awvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      axi.wvalid = 1'b1; axi.wdata = $urandom; axi.wstrb = 4'hF; axi.wlast = 1'b0;
      @(posedge clk); #1;
    end
    arst = 1'b1;
    @(negedge clk);
    chk("midrst_we", 64'(mem_we), 64'd0);
    chk("midrst_wready", 64'(axi.wready), 64'd0);
    @(posedge clk); #1;
    arst = 1'b0;
    axi.wvalid = 1'b0;
    @(negedge clk);
    chk("postrst_awready", 64'(axi.awready), 64'd1);
    chk("postrst_bvalid", 64'(axi.bvalid), 64'd0);
    chk("postrst_wready", 64'(axi.wready), 64'd0);
    do_burst(mk(4'h4, 32'h280, 4'd3, 3'd2, 2'b01, 2'd0), dummy, 1'b0);

    b = rnd();
    for (int n = 0; n < 40; n++) begin
      bit pend;
      nb   = rnd();
      pend = 1'($urandom);
      do_burst(b, nb, pend);
      b = nb;
    end
    do_burst(b, dummy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
